sort_array_mem: RTL and testbench
=================================

// Module: sort_array_mem
// PURPOSE
// - Memory responder at the far end of the sort datapath's read/write memory interface.
// - Holds the array being sorted in 2**ADDR_WDTH words of DATA_WDTH bits.
// - Serves single-beat reads (AR -> R) and writes (AW + W -> B), all with valid/ready handshakes.
// - Sits between the sort datapath/controller and the testbench or host that preloads and inspects the array.
// PARAMETERS
// - ADDR_WDTH  4   word-address width; depth = 2**ADDR_WDTH words
// - DATA_WDTH  32  data word width
// - RESP_WDTH  1   response width; 0 = OKAY, nonzero = ERROR (value 1)
// PORTS
// - clk         in   1          single clock, all state updates on posedge
// - rst         in   1          asynchronous, active-high reset
// - arr_size    in   ADDR_WDTH  number of valid elements; used by bounds check
// - ar_valid    in   1          read address valid
// - ar_ready    out  1          read address accepted
// - ar_address  in   ADDR_WDTH  read word address
// - r_valid     out  1          read data valid
// - r_ready     in   1          initiator accepts read data
// - r_data      out  DATA_WDTH  read data
// - r_resp      out  RESP_WDTH  read response
// - aw_valid    in   1          write address valid
// - aw_ready    out  1          write address accepted
// - aw_address  in   ADDR_WDTH  write word address
// - w_valid     in   1          write data valid
// - w_ready     out  1          write data accepted
// - w_data      in   DATA_WDTH  write data
// - b_valid     out  1          write response valid
// - b_ready     in   1          initiator accepts write response
// - b_resp      out  RESP_WDTH  write response
// BEHAVIOUR
// - Reset:
//   - all array words = 0
//   - r_valid, b_valid, r_data, r_resp, b_resp = 0
//   - ar_ready, aw_ready, w_ready = 1
//   - both FSMs go to IDLE; reset mid-transaction drops the transaction
// - Read FSM, states RD_IDLE and RD_RESP:
//   - RD_IDLE: ar_ready=1. ar_valid&ar_ready: register r_data = mem[ar_address] and r_resp, then -> RD_RESP.
//   - RD_RESP: ar_ready=0, r_valid=1. r_data/r_resp held stable until r_valid&r_ready, then -> RD_IDLE.
//   - Latency: r_valid is high the cycle after the AR handshake; back-to-back reads run every 2 cycles.
// - Write FSM, states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP:
//   - AW and W may arrive in either order or in the same cycle; each is latched once, and its ready drops after capture.
//   - WR_IDLE: both handshakes in one cycle -> commit -> WR_RESP. AW only -> WR_HAVE_AW. W only -> WR_HAVE_W.
//   - WR_HAVE_AW: aw_ready=0, w_ready=1. W handshake -> commit -> WR_RESP.
//   - WR_HAVE_W: w_ready=0, aw_ready=1. AW handshake -> commit -> WR_RESP.
//   - Commit writes mem at the clock edge that enters WR_RESP.
//   - WR_RESP: aw_ready=w_ready=0, b_valid=1, b_resp held until b_valid&b_ready, then -> WR_IDLE.
// - Read/write ordering:
//   - Read and write FSMs run independently and concurrently.
//   - If the AR handshake and a write commit to the same address fall on the same edge, the read returns OLD data.
//   - A read accepted on any later edge sees the new data.
// - Address arithmetic: addresses are unsigned, used modulo 2**ADDR_WDTH; there is no wrap logic beyond that.
// - arr_size: sampled at handshake time only.
// CONFIGURATION
// - MEM_BOUNDS_CHECK_EN defined:
//   - An access with address >= arr_size gets resp=1.
//   - An out-of-range read returns r_data=0; an out-of-range write is not committed (B still issued).
//   - arr_size=0 makes every access an error.
// - MEM_BOUNDS_CHECK_EN undefined:
//   - arr_size is ignored; every access is OKAY (resp=0) and the full depth is accessible.
// TESTING
// - Reset, then read addr 3 (r_ready=1) -> r_valid one cycle after AR handshake, r_data=0, r_resp=0.
// - AW(5)/W(0xDEADBEEF) same cycle, then read 5 -> b_valid next cycle with b_resp=0; read returns 0xDEADBEEF.
// - W(0x11) two cycles before AW(2), b_ready held low 3 cycles -> b_valid held, aw/w_ready=0 throughout; read 2 returns 0x11.
// - Write 7=0xA then AR(7) on the commit edge -> returns old value; a second AR(7) returns 0xA.
// - r_ready low 4 cycles -> r_valid/r_data stable, ar_ready=0; assert rst mid-RD_RESP -> r_valid=0 immediately, memory cleared.
// - MEM_BOUNDS_CHECK_EN, arr_size=4: write 6=0x55 -> b_resp=1; read 6 -> r_resp=1, r_data=0; without macro -> resp=0, data 0x55.

Source files
------------

// File: rtl/sort_array_mem_if.sv
// Read/write memory bus between the sort datapath (master) and the array memory (slave).
// Carries the AR/R and AW/W/B channels plus the current array size used for bounds checking.
interface sort_array_mem_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
);
    logic [ADDR_WDTH-1:0] arr_size;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output arr_size, ar_valid, ar_address, r_ready,
               aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  arr_size, ar_valid, ar_address, r_ready,
               aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/sort_array_mem.sv
// Array memory responder for the sort datapath: single-beat reads and writes with independent FSMs.
// Define MEM_BOUNDS_CHECK_EN to flag accesses at or beyond arr_size as errors.
module sort_array_mem #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input logic             clk,
    input logic             rst,
    sort_array_mem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WDTH;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;

    rd_state_t            rd_state;
    wr_state_t            wr_state;
    logic [DATA_WDTH-1:0] mem [DEPTH];
    logic [ADDR_WDTH-1:0] aw_addr_q;
    logic                 aw_err_q;
    logic [DATA_WDTH-1:0] w_data_q;

    logic ar_hs, aw_hs, w_hs;
    logic ar_oob, aw_oob;
    assign ar_hs = bus.ar_valid & bus.ar_ready;
    assign aw_hs = bus.aw_valid & bus.aw_ready;
    assign w_hs  = bus.w_valid  & bus.w_ready;

`ifdef MEM_BOUNDS_CHECK_EN
    assign ar_oob = bus.ar_address >= bus.arr_size;
    assign aw_oob = bus.aw_address >= bus.arr_size;
`else
    logic unused_arr_size;
    assign unused_arr_size = ^bus.arr_size;
    assign ar_oob = 1'b0;
    assign aw_oob = 1'b0;
`endif

    // Commit happens once both halves of the write are present, whichever came first.
    logic                 commit_en;
    logic [ADDR_WDTH-1:0] commit_addr;
    logic [DATA_WDTH-1:0] commit_data;
    logic                 commit_err;

    always_comb begin
        commit_en   = 1'b0;
        commit_addr = bus.aw_address;
        commit_data = bus.w_data;
        commit_err  = aw_oob;
        case (wr_state)
            WR_IDLE:    commit_en = aw_hs & w_hs;
            WR_HAVE_AW: begin
                commit_en   = w_hs;
                commit_addr = aw_addr_q;
                commit_err  = aw_err_q;
            end
            WR_HAVE_W:  begin
                commit_en   = aw_hs;
                commit_data = w_data_q;
            end
            default:    commit_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state     <= WR_IDLE;
            bus.aw_ready <= 1'b1;
            bus.w_ready  <= 1'b1;
            bus.b_valid  <= 1'b0;
            bus.b_resp   <= '0;
            aw_addr_q    <= '0;
            aw_err_q     <= 1'b0;
            w_data_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit_en) begin
            if (!commit_err) mem[commit_addr] <= commit_data;
            wr_state     <= WR_RESP;
            bus.aw_ready <= 1'b0;
            bus.w_ready  <= 1'b0;
            bus.b_valid  <= 1'b1;
            bus.b_resp   <= RESP_WDTH'(commit_err);
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q    <= bus.aw_address;
                        aw_err_q     <= aw_oob;
                        bus.aw_ready <= 1'b0;
                        wr_state     <= WR_HAVE_AW;
                    end else if (w_hs) begin
                        w_data_q    <= bus.w_data;
                        bus.w_ready <= 1'b0;
                        wr_state    <= WR_HAVE_W;
                    end
                end
                WR_RESP: begin
                    if (bus.b_ready) begin
                        bus.b_valid  <= 1'b0;
                        bus.aw_ready <= 1'b1;
                        bus.w_ready  <= 1'b1;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reading mem with the pre-edge value makes a same-edge read/write return old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state     <= RD_IDLE;
            bus.ar_ready <= 1'b1;
            bus.r_valid  <= 1'b0;
            bus.r_data   <= '0;
            bus.r_resp   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        bus.r_data   <= ar_oob ? '0 : mem[bus.ar_address];
                        bus.r_resp   <= RESP_WDTH'(ar_oob);
                        bus.r_valid  <= 1'b1;
                        bus.ar_ready <= 1'b0;
                        rd_state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (bus.r_ready) begin
                        bus.r_valid  <= 1'b0;
                        bus.ar_ready <= 1'b1;
                        rd_state     <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_array_mem.sv
// Self-checking bench for sort_array_mem: directed scenarios plus randomized traffic against an array model.
module tb_sort_array_mem;
    localparam int AW = 4, DW = 32, RW = 1, DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_array_mem_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();
    sort_array_mem #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] model [DEPTH];

    function automatic logic exp_err(input logic [AW-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return a >= bus.arr_size;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        return exp_err(a) ? '0 : model[a];
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!exp_err(a)) model[a] = d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [RW-1:0] rs, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.ar_valid = 1'b1;
        bus.ar_address = a;
        while (!bus.ar_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        lat = 0;
        while (!bus.r_valid && lat < 50) begin @(negedge clk); lat++; end
        d = bus.r_data;
        rs = bus.r_resp;
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
    endtask

    // mode 0: AW+W together, 1: AW first, 2: W first; gap = idle cycles between them.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int mode,
                            input int gap, input int bdly, output logic [RW-1:0] resp,
                            output logic b_now, output int perr);
        int n;
        perr = 0;
        @(negedge clk);
        if (mode != 2) begin bus.aw_valid = 1'b1; bus.aw_address = a; end
        if (mode != 1) begin bus.w_valid = 1'b1; bus.w_data = d; end
        if (!(bus.aw_ready && bus.w_ready)) perr++;
        @(negedge clk);
        if (mode == 1) begin
            bus.aw_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                if (bus.aw_ready || !bus.w_ready || bus.b_valid) perr++;
                @(negedge clk);
            end
            if (bus.aw_ready || !bus.w_ready) perr++;
            bus.w_valid = 1'b1; bus.w_data = d;
            @(negedge clk);
        end else if (mode == 2) begin
            bus.w_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                if (!bus.aw_ready || bus.w_ready || bus.b_valid) perr++;
                @(negedge clk);
            end
            if (!bus.aw_ready || bus.w_ready) perr++;
            bus.aw_valid = 1'b1; bus.aw_address = a;
            @(negedge clk);
        end
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b0;
        b_now = bus.b_valid;
        for (int i = 0; i < bdly; i++) begin
            if (!bus.b_valid || bus.aw_ready || bus.w_ready || bus.b_resp !== RW'(exp_err(a))) perr++;
            @(negedge clk);
        end
        n = 0;
        while (!bus.b_valid && n < 50) begin @(negedge clk); n++; end
        if (!bus.b_valid) perr++;
        resp = bus.b_resp;
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
        if (bus.b_valid || !bus.aw_ready || !bus.w_ready) perr++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.arr_size = AW'(15);
        bus.ar_valid = 0; bus.ar_address = '0; bus.r_ready = 0;
        bus.aw_valid = 0; bus.aw_address = '0; bus.w_valid = 0; bus.w_data = '0; bus.b_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 11100",
                     {bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid});
        end
        n_chk++;
        if ({bus.r_data, bus.r_resp, bus.b_resp} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got r_data=%h r_resp=%h b_resp=%h expected 0", bus.r_data, bus.r_resp, bus.b_resp);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_basic();
        logic [DW-1:0] d; logic [RW-1:0] rs; int lat;
        do_read(AW'(3), d, rs, lat);
        n_chk++;
        if (lat !== 0) begin n_fail++; $display("FAIL read_latency: got %0d expected 0", lat); end
        n_chk++;
        if ({d, rs} !== {exp_data(AW'(3)), RW'(exp_err(AW'(3)))}) begin
            n_fail++; $display("FAIL read_after_reset: got %h/%h expected %h", d, rs, exp_data(AW'(3)));
        end
    endtask

    task automatic test_write_same_cycle();
        logic [DW-1:0] d; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        do_write(AW'(5), 32'hDEADBEEF, 0, 0, 0, br, bn, perr);
        model_write(AW'(5), 32'hDEADBEEF);
        n_chk++;
        if ({bn, br, perr == 0} !== {1'b1, RW'(exp_err(AW'(5))), 1'b1}) begin
            n_fail++; $display("FAIL write_same_cycle: got b_now=%b b_resp=%h perr=%0d expected 1/0/0", bn, br, perr);
        end
        do_read(AW'(5), d, rs, lat);
        n_chk++;
        if (d !== exp_data(AW'(5))) begin
            n_fail++; $display("FAIL read_deadbeef: got %h expected %h", d, exp_data(AW'(5)));
        end
    endtask

    task automatic test_w_before_aw();
        logic [DW-1:0] d; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        do_write(AW'(2), 32'h11, 2, 1, 3, br, bn, perr);
        model_write(AW'(2), 32'h11);
        n_chk++;
        if ({bn, br, perr == 0} !== {1'b1, RW'(exp_err(AW'(2))), 1'b1}) begin
            n_fail++; $display("FAIL w_before_aw: got b_now=%b b_resp=%h perr=%0d expected 1/0/0", bn, br, perr);
        end
        do_write(AW'(4), 32'h44, 1, 2, 1, br, bn, perr);
        model_write(AW'(4), 32'h44);
        n_chk++;
        if ({bn, perr == 0} !== 2'b11) begin
            n_fail++; $display("FAIL aw_before_w: got b_now=%b perr=%0d expected 1/0", bn, perr);
        end
        do_read(AW'(2), d, rs, lat);
        n_chk++;
        if (d !== exp_data(AW'(2))) begin
            n_fail++; $display("FAIL read_w_first: got %h expected %h", d, exp_data(AW'(2)));
        end
    endtask

    task automatic test_same_edge_order();
        logic [DW-1:0] d, old; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        do_write(AW'(7), 32'h3, 0, 0, 0, br, bn, perr);
        model_write(AW'(7), 32'h3);
        old = exp_data(AW'(7));
        @(negedge clk);
        bus.aw_valid = 1; bus.aw_address = AW'(7); bus.w_valid = 1; bus.w_data = 32'hA;
        bus.ar_valid = 1; bus.ar_address = AW'(7);
        @(negedge clk);
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
        n_chk++;
        if ({bus.r_valid, bus.b_valid, bus.r_data} !== {2'b11, old}) begin
            n_fail++; $display("FAIL same_edge_old: got rv=%b bv=%b data=%h expected 1/1/%h",
                               bus.r_valid, bus.b_valid, bus.r_data, old);
        end
        bus.r_ready = 1; bus.b_ready = 1;
        @(negedge clk);
        bus.r_ready = 0; bus.b_ready = 0;
        model_write(AW'(7), 32'hA);
        do_read(AW'(7), d, rs, lat);
        n_chk++;
        if (d !== exp_data(AW'(7))) begin
            n_fail++; $display("FAIL same_edge_new: got %h expected %h", d, exp_data(AW'(7)));
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        @(negedge clk);
        bus.ar_valid = 1; bus.ar_address = AW'(5); bus.r_ready = 1;
        repeat (6) begin @(negedge clk); if (bus.r_valid) cnt++; end
        bus.ar_valid = 0;
        @(negedge clk);
        bus.r_ready = 0;
        n_chk++;
        if (cnt !== 3) begin n_fail++; $display("FAIL back_to_back: got %0d beats expected 3", cnt); end
    endtask

    task automatic test_r_stall_and_reset();
        logic [DW-1:0] d, v; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        v = $urandom;
        do_write(AW'(9), v, 0, 0, 0, br, bn, perr);
        model_write(AW'(9), v);
        @(negedge clk);
        bus.ar_valid = 1; bus.ar_address = AW'(9);
        @(negedge clk);
        bus.ar_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({bus.r_valid, bus.ar_ready, bus.r_data} !== {2'b10, exp_data(AW'(9))}) begin
                n_fail++; $display("FAIL r_stall cyc%0d: got rv=%b ar_rdy=%b data=%h expected 1/0/%h",
                                   i, bus.r_valid, bus.ar_ready, bus.r_data, exp_data(AW'(9)));
            end
            @(negedge clk);
        end
        #2 rst = 1;
        #1;
        n_chk++;
        if ({bus.r_valid, bus.ar_ready} !== 2'b01) begin
            n_fail++; $display("FAIL async_reset: got rv=%b ar_rdy=%b expected 0/1", bus.r_valid, bus.ar_ready);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        do_read(AW'(9), d, rs, lat);
        n_chk++;
        if (d !== '0) begin n_fail++; $display("FAIL mem_cleared: got %h expected 0", d); end
    endtask

    task automatic test_bounds();
        logic [DW-1:0] d; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        bus.arr_size = AW'(4);
        do_write(AW'(6), 32'h55, 0, 0, 0, br, bn, perr);
        model_write(AW'(6), 32'h55);
        do_read(AW'(6), d, rs, lat);
`ifdef MEM_BOUNDS_CHECK_EN
        n_chk++;
        if ({br, rs, d} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL bounds_oob: got b=%h r=%h d=%h expected 1/1/0", br, rs, d);
        end
`else
        n_chk++;
        if ({br, rs, d} !== {1'b0, 1'b0, 32'h55}) begin
            n_fail++; $display("FAIL bounds_off: got b=%h r=%h d=%h expected 0/0/55", br, rs, d);
        end
`endif
        bus.arr_size = AW'(0);
        do_read(AW'(0), d, rs, lat);
        n_chk++;
        if ({rs, d} !== {RW'(exp_err(AW'(0))), exp_data(AW'(0))}) begin
            n_fail++; $display("FAIL size_zero: got r=%h d=%h expected %h/%h", rs, d, exp_err(AW'(0)), exp_data(AW'(0)));
        end
        bus.arr_size = AW'(15);
    endtask

    task automatic test_random();
        logic [DW-1:0] d, v; logic [RW-1:0] rs, br; logic bn; int lat, perr;
        logic [AW-1:0] a;
        for (int it = 0; it < 60; it++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            bus.arr_size = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom;
                do_write(a, v, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br, bn, perr);
                n_chk++;
                if ({bn, br, perr == 0} !== {1'b1, RW'(exp_err(a)), 1'b1}) begin
                    n_fail++; $display("FAIL rand_write it%0d a=%0d: got b_now=%b b_resp=%h perr=%0d expected 1/%h/0",
                                       it, a, bn, br, perr, exp_err(a));
                end
                model_write(a, v);
            end else begin
                do_read(a, d, rs, lat);
                n_chk++;
                if ({d, rs, lat == 0} !== {exp_data(a), RW'(exp_err(a)), 1'b1}) begin
                    n_fail++; $display("FAIL rand_read it%0d a=%0d: got %h/%h lat=%0d expected %h/%h lat=0",
                                       it, a, d, rs, lat, exp_data(a), exp_err(a));
                end
            end
        end
        bus.arr_size = AW'(15);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_same_cycle();
        test_w_before_aw();
        test_same_edge_order();
        test_back_to_back();
        test_r_stall_and_reset();
        test_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
